// File: rtl/otbn_pq_lane_sequencer.sv
// PQ lane sequencer: walks one 32-bit ALU operation across the selected lanes of a
// 256-bit WDR pair and merges each lane's ALU results into full-width result registers.

package otbn_pq_pkg;
  parameter int unsigned PQLEN    = 32;
  parameter int unsigned WLEN     = 256;
  parameter int unsigned PQ_LANES = WLEN / PQLEN;
  parameter int unsigned PQ_SELW  = $clog2(PQ_LANES);

  typedef struct packed {
    logic [7:0]         op;
    logic [WLEN-1:0]    operand_a;
    logic [WLEN-1:0]    operand_b;
    logic [PQ_SELW-1:0] operand_a_w_sel;
    logic [PQ_SELW-1:0] operand_b_w_sel;
    logic [PQ_SELW-1:0] d_w_sel;
    logic [PQLEN-1:0]   twiddle;
    logic [PQLEN-1:0]   imm;
    logic               imm_sel;
    logic [PQLEN-1:0]   scale;
    logic [PQLEN-1:0]   prime;
    logic [PQLEN-1:0]   prime_dash;
  } alu_pq_operation_t;
endpackage

module otbn_pq_lane_sequencer
  import otbn_pq_pkg::*;
#(
  parameter int unsigned LANES = WLEN / PQLEN
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [7:0]          op_i,
  input  logic                imm_sel_i,
  input  logic [PQLEN-1:0]    imm_i,
  input  logic [LANES-1:0]    lane_mask_i,
  input  logic [WLEN-1:0]     wa_i,
  input  logic [WLEN-1:0]     wb_i,
  input  logic [WLEN-1:0]     twiddle_vec_i,
  input  logic [PQLEN-1:0]    scale_i,
  input  logic [PQLEN-1:0]    prime_i,
  input  logic [PQLEN-1:0]    prime_dash_i,
  output alu_pq_operation_t   alu_operation_o,
  input  logic [WLEN-1:0]     alu_rs0_i,
  input  logic [WLEN-1:0]     alu_rs1_i,
  input  logic [WLEN-1:0]     alu_rd_i,
  output logic [WLEN-1:0]     rs0_o,
  output logic [WLEN-1:0]     rs1_o,
  output logic [WLEN-1:0]     rd_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned BW = $clog2(WLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]       op;
    logic             imm_sel;
    logic [PQLEN-1:0] imm;
    logic [WLEN-1:0]  wa;
    logic [WLEN-1:0]  wb;
    logic [WLEN-1:0]  tw;
    logic [PQLEN-1:0] scale;
    logic [PQLEN-1:0] prime;
    logic [PQLEN-1:0] prime_dash;
  } cfg_t;

  state_e           state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [LANES-1:0] remain_q, remain_d;
  logic [LANES-1:0] remain_nxt;
  cfg_t             cfg_q, cfg_d;
  logic [WLEN-1:0]  rs0_q, rs0_d;
  logic [WLEN-1:0]  rs1_q, rs1_d;
  logic [WLEN-1:0]  rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BW-1:0]    base;

  function automatic logic [LW-1:0] lowest_set(input logic [LANES-1:0] m);
    lowest_set = '0;
    for (int unsigned i = LANES; i > 0; i--) begin
      if (m[i-1]) lowest_set = LW'(i - 1);
    end
  endfunction

  assign base       = BW'(lane_q) * BW'(PQLEN);
  assign remain_nxt = remain_q & ~(LANES'(1) << lane_q);

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    remain_d = remain_q;
    cfg_d    = cfg_q;
    rs0_d    = rs0_q;
    rs1_d    = rs1_q;
    rd_d     = rd_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          cfg_d.op         = op_i;
          cfg_d.imm_sel    = imm_sel_i;
          cfg_d.imm        = imm_i;
          cfg_d.wa         = wa_i;
          cfg_d.wb         = wb_i;
          cfg_d.tw         = twiddle_vec_i;
          cfg_d.scale      = scale_i;
          cfg_d.prime      = prime_i;
          cfg_d.prime_dash = prime_dash_i;
          rs0_d            = wa_i;
          rs1_d            = wb_i;
          rd_d             = '0;
          remain_d         = lane_mask_i;
          lane_d           = lowest_set(lane_mask_i);
          state_d          = (lane_mask_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Abort discards the in-flight lane so only fully completed lanes are merged.
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          rs0_d[base +: PQLEN] = alu_rs0_i[base +: PQLEN];
          rs1_d[base +: PQLEN] = alu_rs1_i[base +: PQLEN];
          rd_d[base +: PQLEN]  = alu_rd_i[base +: PQLEN];
          remain_d             = remain_nxt;
          lane_d               = lowest_set(remain_nxt);
          if (remain_nxt == '0) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      remain_q <= '0;
      cfg_q    <= '0;
      rs0_q    <= '0;
      rs1_q    <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      remain_q <= remain_d;
      cfg_q    <= cfg_d;
      rs0_q    <= rs0_d;
      rs1_q    <= rs1_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    alu_operation_o = '0;
    if (state_q == RUN) begin
      alu_operation_o.op              = cfg_q.op;
      alu_operation_o.operand_a       = cfg_q.wa;
      alu_operation_o.operand_b       = cfg_q.wb;
      alu_operation_o.operand_a_w_sel = PQ_SELW'(lane_q);
      alu_operation_o.operand_b_w_sel = PQ_SELW'(lane_q);
      alu_operation_o.d_w_sel         = PQ_SELW'(lane_q);
      alu_operation_o.twiddle         = cfg_q.tw[base +: PQLEN];
      alu_operation_o.imm             = cfg_q.imm;
      alu_operation_o.imm_sel         = cfg_q.imm_sel;
      alu_operation_o.scale           = cfg_q.scale;
      alu_operation_o.prime           = cfg_q.prime;
      alu_operation_o.prime_dash      = cfg_q.prime_dash;
    end
  end

  assign rs0_o  = rs0_q;
  assign rs1_o  = rs1_q;
  assign rd_o   = rd_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_otbn_pq_lane_sequencer.sv
// Bench for otbn_pq_lane_sequencer: a small lane ALU stands in for the PQ ALU, and
// expected vectors come from whole-vector lane arithmetic over the mask.

module tb_otbn_pq_lane_sequencer;
  import otbn_pq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               start_i, abort_i, imm_sel_i;
  logic [7:0]         op_i, lane_mask_i;
  logic [31:0]        imm_i, scale_i, prime_i, prime_dash_i;
  logic [255:0]       wa_i, wb_i, tw_i;
  alu_pq_operation_t  alu_op;
  logic [255:0]       alu_rs0, alu_rs1, alu_rd;
  logic [255:0]       rs0, rs1, rd;
  logic               busy, done;

  otbn_pq_lane_sequencer #(.LANES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .op_i(op_i), .imm_sel_i(imm_sel_i), .imm_i(imm_i), .lane_mask_i(lane_mask_i),
    .wa_i(wa_i), .wb_i(wb_i), .twiddle_vec_i(tw_i), .scale_i(scale_i),
    .prime_i(prime_i), .prime_dash_i(prime_dash_i), .alu_operation_o(alu_op),
    .alu_rs0_i(alu_rs0), .alu_rs1_i(alu_rs1), .alu_rd_i(alu_rd),
    .rs0_o(rs0), .rs1_o(rs1), .rd_o(rd), .busy_o(busy), .done_o(done)
  );

  // Lane arithmetic: 0x42 modular add into rs0, 0x27 modular subtract into rd,
  // anything else a*twiddle+imm mod q into rd; rs0/rs1 otherwise echo the operands.
  function automatic void lane_fn(input logic [7:0] op, input logic [31:0] a, b, tw, imm, q,
                                  output logic [31:0] r0, r1, r2);
    r0 = a; r1 = b; r2 = '0;
    if (q == 0) begin
      r0 = '0; r1 = '0;
    end else if (op == 8'h42) begin
      r0 = 32'((64'(a) + 64'(b)) % 64'(q));
    end else if (op == 8'h27) begin
      r2 = 32'((64'(a) + 64'(q) - 64'(b)) % 64'(q));
    end else begin
      r2 = 32'((64'(a) * 64'(tw) + 64'(imm)) % 64'(q));
    end
  endfunction

  logic [31:0] ar0, ar1, ar2;
  always_comb begin
    alu_rs0 = '0; alu_rs1 = '0; alu_rd = '0;
    lane_fn(alu_op.op, alu_op.operand_a[32*alu_op.operand_a_w_sel +: 32],
            alu_op.operand_b[32*alu_op.operand_b_w_sel +: 32], alu_op.twiddle,
            alu_op.imm, alu_op.prime, ar0, ar1, ar2);
    alu_rs0[32*alu_op.d_w_sel +: 32] = ar0;
    alu_rs1[32*alu_op.d_w_sel +: 32] = ar1;
    alu_rd[32*alu_op.d_w_sel +: 32]  = ar2;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_vec(input logic [7:0] op, mask, input logic [255:0] a, b, tw,
                            input logic [31:0] imm, q, output logic [255:0] e0, e1, e2);
    logic [31:0] r0, r1, r2;
    for (int l = 0; l < 8; l++) begin
      if (mask[l]) lane_fn(op, a[32*l +: 32], b[32*l +: 32], tw[32*l +: 32], imm, q, r0, r1, r2);
      else begin r0 = a[32*l +: 32]; r1 = b[32*l +: 32]; r2 = '0; end
      e0[32*l +: 32] = r0; e1[32*l +: 32] = r1; e2[32*l +: 32] = r2;
    end
  endtask

  function automatic logic [31:0] exp_seq(input logic [7:0] mask);
    int n = 0;
    exp_seq = '0;
    for (int l = 0; l < 8; l++) if (mask[l]) begin exp_seq[4*n +: 4] = 4'(l); n++; end
  endfunction

  // Called 1 time unit after a clock edge; returns in the done cycle (or after the bound).
  task automatic run_op(input logic [7:0] op, mask, input logic [255:0] a, b, tw,
                        input logic [31:0] imm, q, output int lat, output logic [31:0] seq,
                        output int nseq, output int errs);
    op_i = op; lane_mask_i = mask; wa_i = a; wb_i = b; tw_i = tw; imm_i = imm;
    prime_i = q; prime_dash_i = 32'h1234_5678; scale_i = 32'd99; imm_sel_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int l = 0; l < 8; l++) begin
      wa_i[32*l +: 32] = $urandom; wb_i[32*l +: 32] = $urandom; tw_i[32*l +: 32] = $urandom;
    end
    op_i = 8'($urandom); lane_mask_i = 8'($urandom); prime_i = $urandom; imm_i = $urandom;
    lat = -1; seq = '0; nseq = 0; errs = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        lat = k;
        if (alu_op != '0) errs++;
        break;
      end
      if (!busy) errs++;
      else begin
        if (nseq < 8) seq[4*nseq +: 4] = {1'b0, alu_op.d_w_sel};
        nseq++;
        if (alu_op.operand_a_w_sel != alu_op.d_w_sel || alu_op.operand_b_w_sel != alu_op.d_w_sel ||
            alu_op.twiddle != tw[32*alu_op.d_w_sel +: 32] || alu_op.op != op ||
            alu_op.prime != q || alu_op.imm != imm || alu_op.operand_a != a ||
            alu_op.operand_b != b || alu_op.scale != 32'd99 ||
            alu_op.prime_dash != 32'h1234_5678 || !alu_op.imm_sel) errs++;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [7:0]  op, mask;
    logic [31:0] a, b, q, e0, e1, e2;
    int          lat;
  } vec_t;

  vec_t vt[5];

  task automatic full_check(input string tag, input logic [7:0] op, mask,
                            input logic [255:0] a, b, tw, input logic [31:0] imm, q,
                            input logic [255:0] e0, e1, e2);
    int lat, nseq, errs;
    logic [31:0] seq;
    run_op(op, mask, a, b, tw, imm, q, lat, seq, nseq, errs);
    chk({tag, " latency"}, 256'(lat), 256'(1 + $countones(mask)));
    chk({tag, " rs0"}, rs0, e0);
    chk({tag, " rs1"}, rs1, e1);
    chk({tag, " rd"}, rd, e2);
    chk({tag, " lane count"}, 256'(nseq), 256'($countones(mask)));
    chk({tag, " w_sel sequence"}, 256'(seq), 256'(exp_seq(mask)));
    chk({tag, " alu fields"}, 256'(errs), 256'(0));
    @(posedge clk); #1;
    chk({tag, " rs0 stable"}, rs0, e0);
    chk({tag, " idle flags/op"}, 256'({busy, done, alu_op != '0}), 256'(0));
  endtask

  initial begin
    logic [255:0] a, b, tw, e0, e1, e2;
    logic [31:0] q, imm;
    logic [7:0] op, mask;
    int dseen;

    vt[0] = '{op: 8'h42, mask: 8'hFF, a: 3000, b: 1000, q: 3329, e0: 671, e1: 1000, e2: 0, lat: 9};
    vt[1] = '{op: 8'h27, mask: 8'hA4, a: 5, b: 9, q: 3329, e0: 5, e1: 9, e2: 3325, lat: 4};
    vt[2] = '{op: 8'h42, mask: 8'h00, a: 3000, b: 1000, q: 3329, e0: 3000, e1: 1000, e2: 0, lat: 1};
    vt[3] = '{op: 8'h42, mask: 8'h80, a: 3328, b: 1, q: 3329, e0: 0, e1: 1, e2: 0, lat: 2};
    vt[4] = '{op: 8'h27, mask: 8'h01, a: 9, b: 5, q: 3329, e0: 9, e1: 5, e2: 4, lat: 2};

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; op_i = '0; imm_sel_i = 1'b0; imm_i = '0;
    lane_mask_i = '0; wa_i = '0; wb_i = '0; tw_i = '0; scale_i = '0; prime_i = '0;
    prime_dash_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rs0", rs0, '0);
    chk("reset rs1/rd", rs1 | rd, '0);
    chk("reset flags/op", 256'({busy, done, alu_op != '0}), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      int lat, nseq, errs;
      logic [31:0] seq;
      a = {8{vt[i].a}}; b = {8{vt[i].b}}; tw = '0;
      for (int l = 0; l < 8; l++) begin
        e0[32*l +: 32] = vt[i].mask[l] ? vt[i].e0 : vt[i].a;
        e1[32*l +: 32] = vt[i].mask[l] ? vt[i].e1 : vt[i].b;
        e2[32*l +: 32] = vt[i].mask[l] ? vt[i].e2 : 32'd0;
      end
      run_op(vt[i].op, vt[i].mask, a, b, tw, 32'd0, vt[i].q, lat, seq, nseq, errs);
      chk($sformatf("vec%0d latency", i), 256'(lat), 256'(vt[i].lat));
      chk($sformatf("vec%0d rs0", i), rs0, e0);
      chk($sformatf("vec%0d rs1", i), rs1, e1);
      chk($sformatf("vec%0d rd", i), rd, e2);
      chk($sformatf("vec%0d w_sel seq", i), 256'(seq), 256'(exp_seq(vt[i].mask)));
      chk($sformatf("vec%0d alu fields", i), 256'(errs), 256'(0));
      @(posedge clk); #1;
    end

    // Twiddle indexing: lane n twiddle = n+1.
    for (int l = 0; l < 8; l++) begin
      a[32*l +: 32] = 32'(100 + l); b[32*l +: 32] = 32'd7; tw[32*l +: 32] = 32'(l + 1);
    end
    expect_vec(8'h10, 8'hFF, a, b, tw, 32'd3, 32'd3329, e0, e1, e2);
    full_check("twiddle", 8'h10, 8'hFF, a, b, tw, 32'd3, 32'd3329, e0, e1, e2);

    for (int it = 0; it < 24; it++) begin
      int sel;
      sel  = $urandom_range(0, 2);
      op   = (sel == 0) ? 8'h42 : (sel == 1) ? 8'h27 : 8'h10;
      mask = 8'($urandom);
      q    = ($urandom_range(0, 1) == 0) ? 32'd3329 : 32'd8380417;
      imm  = $urandom;
      for (int l = 0; l < 8; l++) begin
        a[32*l +: 32] = $urandom % q; b[32*l +: 32] = $urandom % q; tw[32*l +: 32] = $urandom;
      end
      expect_vec(op, mask, a, b, tw, imm, q, e0, e1, e2);
      full_check($sformatf("rand%0d", it), op, mask, a, b, tw, imm, q, e0, e1, e2);
    end

    // Abort in the third RUN cycle, with a second start issued while busy.
    op_i = 8'h42; lane_mask_i = 8'hFF; wa_i = {8{32'd3000}}; wb_i = {8{32'd1000}};
    tw_i = '0; imm_i = '0; prime_i = 32'd3329; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    @(posedge clk); #1; start_i = 1'b1; lane_mask_i = 8'h01;
    @(posedge clk); #1; start_i = 1'b0;
    chk("abort third lane sel", 256'(alu_op.d_w_sel), 256'(2));
    abort_i = 1'b1;
    @(posedge clk); #1; abort_i = 1'b0;
    chk("abort idle flags", 256'({busy, done}), 256'(0));
    chk("abort partial rs0", rs0, {{6{32'd3000}}, {2{32'd671}}});
    chk("abort rs1/rd", {rs1[127:0], rd[127:0]}, {{4{32'd1000}}, 128'd0});
    dseen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) dseen++;
    end
    chk("abort no done", 256'(dseen), 256'(0));

    // Abort coincident with start in IDLE is not accepted.
    start_i = 1'b1; abort_i = 1'b1; lane_mask_i = 8'hFF;
    @(posedge clk); #1; start_i = 1'b0; abort_i = 1'b0;
    chk("idle abort blocks start", 256'({busy, done}), 256'(0));
    chk("idle abort holds rs0", rs0, {{6{32'd3000}}, {2{32'd671}}});

    expect_vec(8'h42, 8'hFF, {8{32'd3000}}, {8{32'd1000}}, '0, 32'd0, 32'd3329, e0, e1, e2);
    full_check("restart", 8'h42, 8'hFF, {8{32'd3000}}, {8{32'd1000}}, '0, 32'd0, 32'd3329,
               e0, e1, e2);

    // Asynchronous reset mid-RUN.
    op_i = 8'h42; lane_mask_i = 8'hFF; wa_i = {8{32'd3000}}; wb_i = {8{32'd1000}};
    prime_i = 32'd3329; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async rst rs0", rs0, '0);
    chk("async rst rs1/rd", rs1 | rd, '0);
    chk("async rst flags/op", 256'({busy, done, alu_op != '0}), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst idle", 256'({busy, done}), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
